icache_tag_ctrl: RTL and testbench

- Controller and master of the I-cache tag RAM, a simple dual-port RAM with 256 entries × 21 bits and a registered read (1-cycle latency, no output register).
- Drives the RAM's write port and read port; the RAM sits outside this block.
- Clears all tags after reset and on a flush request, writes tags on line refill, and performs pipelined hit/miss lookups for the fetch unit.
- Tag entry layout: bit 20 = valid, bits 19:0 = addr[31:12]. Index is addr[11:4]; each line is 16 bytes.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_tag_sweep.sv | 40 ++++
 rtl/icache_tag_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_icache_tag_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, tag-entry layout, FSM states and address-slicing helpers
// for the I-cache tag controller.
package icache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned OFS_W    = 4;
    localparam int unsigned TAG_W    = ADDR_W - IDX_W - OFS_W;
    localparam int unsigned NUM_SETS = 256;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFS_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/icache_tag_sweep.sv
// Invalidate sweep: walks every tag index once, writing an all-zero entry per
// cycle while enabled; shared by the post-reset clear and the flush.
module icache_tag_sweep
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic             wr_en_c,
    output logic [IDX_W-1:0] wr_addr_o,
    output tag_entry_t       wr_data_c,
    output logic             done_c
);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    // NUM_SETS equals 2**IDX_W, so the counter wraps back to 0 after the last
    // index and the next sweep starts from 0 with no explicit reload.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_en_c   = en_i & ~rst;
    assign wr_addr_o = cnt_q;
    assign wr_data_c = '0;
    assign done_c    = en_i && (cnt_q == IDX_W'(NUM_SETS - 1));

endmodule

// File: rtl/icache_tag_ctrl.sv
// I-cache tag RAM controller: clear/flush sweeps, refill writes and a
// two-stage pipelined hit/miss lookup with write forwarding.
// Optional hit/miss counters are built when ICACHE_TAG_STATS_EN is defined.
module icache_tag_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              flush_req,
    output logic              busy,
    output logic [TAG_W:0]    tag_wr_data,
    output logic [IDX_W-1:0]  tag_wr_addr,
    output logic              tag_wr_en,
    output logic [IDX_W-1:0]  tag_rd_addr,
    input  logic [TAG_W:0]    tag_rd_data
`ifdef ICACHE_TAG_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    state_e           state_q;
    state_e           state_d;

    logic             sweep_en;
    logic             sweep_wr_en;
    logic [IDX_W-1:0] sweep_addr;
    tag_entry_t       sweep_data;
    logic             sweep_done;

    logic             req_fire;
    logic             fill_fire;
    tag_entry_t       fill_entry;

    logic [IDX_W-1:0]  rd_addr_q;
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              fwd_valid_q;
    logic [IDX_W-1:0]  fwd_idx_q;
    tag_entry_t        fwd_data_q;
    tag_entry_t        cmp_entry;
    logic              hit_c;

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    assign sweep_en = (state_q != RUN);

    icache_tag_sweep u_sweep (
        .clk       (clk),
        .rst       (rst),
        .en_i      (sweep_en),
        .wr_en_c   (sweep_wr_en),
        .wr_addr_o (sweep_addr),
        .wr_data_c (sweep_data),
        .done_c    (sweep_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            CLEAR, FLUSH: begin
                if (sweep_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy       = 1'b0;
                fill_ready = 1'b1;
                req_ready  = ~flush_req;
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign req_fire   = req_valid && req_ready;
    assign fill_fire  = fill_valid && fill_ready;
    assign fill_entry = tag_entry_t'({1'b1, addr_tag(fill_addr)});

    // Write port: the sweep owns it outside RUN; fills only arrive in RUN.
    always_comb begin
        tag_wr_en   = 1'b0;
        tag_wr_addr = sweep_addr;
        tag_wr_data = sweep_data;
        if (state_q != RUN) begin
            tag_wr_en = sweep_wr_en;
        end else if (fill_fire) begin
            tag_wr_en   = 1'b1;
            tag_wr_addr = addr_idx(fill_addr);
            tag_wr_data = fill_entry;
        end
    end

    assign tag_rd_addr = req_fire ? addr_idx(req_addr) : rd_addr_q;

    // The RAM read-during-write result is undefined, so fills landing in the
    // accept or compare cycle override whatever the RAM returned.
    always_comb begin
        cmp_entry = tag_entry_t'(tag_rd_data);
        if (fill_fire && (addr_idx(fill_addr) == addr_idx(s1_addr_q))) begin
            cmp_entry = fill_entry;
        end else if (fwd_valid_q && (fwd_idx_q == addr_idx(s1_addr_q))) begin
            cmp_entry = fwd_data_q;
        end
        hit_c = cmp_entry.valid && (cmp_entry.tag == addr_tag(s1_addr_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            s1_valid_q  <= req_fire;
            fwd_valid_q <= fill_fire;
            rsp_valid_q <= s1_valid_q;
            if (req_fire) begin
                rd_addr_q <= addr_idx(req_addr);
                s1_addr_q <= req_addr;
            end
            if (fill_fire) begin
                fwd_idx_q  <= addr_idx(fill_addr);
                fwd_data_q <= fill_entry;
            end
            if (s1_valid_q) begin
                rsp_hit_q  <= hit_c;
                rsp_addr_q <= s1_addr_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_addr  = rsp_addr_q;

`ifdef ICACHE_TAG_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Counters survive flushes; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_valid_q) begin
            if (rsp_hit_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Scoreboard bench for icache_tag_ctrl with a behavioural tag RAM model.
module tb_icache_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] rsp_addr;
    logic        fill_valid;
    logic        fill_ready;
    logic [31:0] fill_addr;
    logic        flush_req;
    logic        busy;
    logic [20:0] tag_wr_data;
    logic [7:0]  tag_wr_addr;
    logic        tag_wr_en;
    logic [7:0]  tag_rd_addr;
    logic [20:0] tag_rd_data;
`ifdef ICACHE_TAG_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_tag_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_addr    (rsp_addr),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_addr   (fill_addr),
        .flush_req   (flush_req),
        .busy        (busy),
        .tag_wr_data (tag_wr_data),
        .tag_wr_addr (tag_wr_addr),
        .tag_wr_en   (tag_wr_en),
        .tag_rd_addr (tag_rd_addr),
        .tag_rd_data (tag_rd_data)
`ifdef ICACHE_TAG_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    // Tag RAM starts with valid entries holding tag 1, so a missing clear shows up as a hit.
    logic [20:0] mem [256] = '{default: 21'h100001};

    always @(posedge clk) begin
        if (tag_wr_en) mem[tag_wr_addr] <= tag_wr_data;
        tag_rd_data <= mem[tag_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        hit;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every response must match the head of the scoreboard, in its cycle.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "rsp_unexpected", 64'(rsp_addr), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (rsp_addr == e.addr && rsp_hit == e.hit && cyc == e.cyc) passed++;
                else $display("FAIL rsp: addr 0x%h hit %0d cyc %0d, expected addr 0x%h hit %0d cyc %0d",
                              rsp_addr, rsp_hit, cyc, e.addr, e.hit, e.cyc);
            end
        end
    end

    // One cycle of stimulus; er is whether the lookup must be accepted.
    task automatic step(input bit lv, input logic [31:0] la, input bit eh, input bit er,
                        input bit fv, input logic [31:0] fa, input bit fl);
        exp_t e;
        req_valid  = lv;
        req_addr   = la;
        fill_valid = fv;
        fill_addr  = fa;
        flush_req  = fl;
        #1;
        if (lv) begin
            chk(req_ready == er, "req_ready", 64'(req_ready), 64'(er));
            if (er) begin
                chk(tag_rd_addr == la[11:4], "rd_addr", 64'(tag_rd_addr), 64'(la[11:4]));
                e.cyc  = cyc + 2;
                e.hit  = eh;
                e.addr = la;
                exp_q.push_back(e);
            end
        end
        if (fv) begin
            chk(fill_ready && tag_wr_en && tag_wr_addr == fa[11:4] && tag_wr_data == {1'b1, fa[31:12]},
                "fill_wr", {fill_ready, tag_wr_en, 6'd0, tag_wr_addr, 11'd0, tag_wr_data},
                {2'b11, 6'd0, fa[11:4], 11'd0, 1'b1, fa[31:12]});
        end
        @(negedge clk);
        req_valid  = 1'b0;
        fill_valid = 1'b0;
        flush_req  = 1'b0;
    endtask

    task automatic look(input logic [31:0] a, input bit eh);
        step(1'b1, a, eh, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic fill(input logic [31:0] a);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, a, 1'b0);
    endtask

    // Checks n sweep cycles from index 0; with full set, also the exit to RUN.
    task automatic sweep_check(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            #1;
            chk(tag_wr_en && busy && !req_ready && !fill_ready && tag_wr_addr == 8'(k) && tag_wr_data == 21'd0,
                "sweep", {tag_wr_en, busy, req_ready, fill_ready, tag_wr_addr, tag_wr_data},
                {4'b1100, 8'(k), 21'd0});
            @(negedge clk);
        end
        if (full) begin
            #1;
            chk(!busy && !tag_wr_en && fill_ready, "sweep_exit", {busy, tag_wr_en, fill_ready}, 64'b001);
            @(negedge clk);
        end
    endtask

    task automatic mem_zero_check();
        bit ok = 1'b1;
        for (int i = 0; i < 256; i++) if (mem[i] != 21'd0) ok = 1'b0;
        chk(ok, "mem_cleared", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        fill_valid = 1'b0;
        fill_addr  = '0;
        flush_req  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(busy && !req_ready && !fill_ready && !rsp_valid && !rsp_hit && rsp_addr == 32'd0 && !tag_wr_en,
            "reset_outputs", {busy, req_ready, fill_ready, rsp_valid, rsp_hit, tag_wr_en, rsp_addr},
            {6'b100000, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        sweep_check(256, 1'b1);
        mem_zero_check();

        // Cold miss, then refill and hit/miss on same index
        look(32'h0000_1230, 1'b0);
        repeat (3) @(negedge clk);
        fill(32'h0000_1230);
        @(negedge clk);
        look(32'h0000_123C, 1'b1);
        look(32'h0000_2230, 1'b0);
        repeat (3) @(negedge clk);

        // Fill in the accept cycle, then fill in the compare cycle
        step(1'b1, 32'hABCD_E560, 1'b1, 1'b1, 1'b1, 32'hABCD_E560, 1'b0);
        repeat (3) @(negedge clk);
        look(32'h1234_5670, 1'b1);
        fill(32'h1234_5670);
        repeat (3) @(negedge clk);

        // Four back-to-back lookups
        look(32'h0000_1230, 1'b1);
        look(32'h0000_2230, 1'b0);
        look(32'hABCD_E560, 1'b1);
        look(32'h1234_5670, 1'b1);
        repeat (3) @(negedge clk);

        // Flush on the third cycle, with a simultaneous fill that the sweep erases
        look(32'h0000_123C, 1'b1);
        look(32'hABCD_E560, 1'b1);
        step(1'b1, 32'h0000_1230, 1'b0, 1'b0, 1'b1, 32'h0000_7770, 1'b1);
        sweep_check(256, 1'b1);
        look(32'h0000_1230, 1'b0);
        look(32'h0000_7770, 1'b0);
        look(32'hABCD_E560, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the middle of the clear sweep restarts from index 0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sweep_check(100, 1'b0);
        #1;
        chk(tag_wr_addr == 8'd100, "sweep_at_100", 64'(tag_wr_addr), 64'd100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep_check(256, 1'b1);
        mem_zero_check();

`ifdef ICACHE_TAG_STATS_EN
        fill(32'h0000_1230);
        @(negedge clk);
        look(32'h0000_1230, 1'b1);
        look(32'h0000_1234, 1'b1);
        look(32'h0000_2230, 1'b0);
        look(32'h0000_1238, 1'b1);
        look(32'h0000_9990, 1'b0);
        repeat (4) @(negedge clk);
        chk(hit_cnt == 32'd3 && miss_cnt == 32'd2, "stats", {hit_cnt, miss_cnt}, {32'd3, 32'd2});
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        sweep_check(256, 1'b1);
        chk(hit_cnt == 32'd3 && miss_cnt == 32'd2, "stats_after_flush", {hit_cnt, miss_cnt}, {32'd3, 32'd2});
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
